rgb_fade_sequencer: RTL

- Sequencer that drives the three RGB PWM duty inputs through a fixed six-colour palette: red, yellow, green, cyan, blue, magenta, then back to red.
- Between colours it ramps each channel one LSB per step tick. At each colour it holds for a programmable number of ticks.
- Sits between the board top and three pwm instances, and replaces free-running colour generation with a controllable start/pause/stop schedule.
- Outputs are active-high duty values. Pin inversion for the LED drivers stays in top.

---
 rtl/rgb_fade_sequencer_if.sv | 25 ++
 rtl/rgb_fade_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rgb_fade_sequencer_if.sv
// Control and duty-output bundle between the board top and the RGB fade sequencer.
// Level semantics: enable and pause are sampled on every rising clk edge; every output is registered.
interface rgb_fade_sequencer_if #(
  parameter int DUTY_W = 8
);
  logic              enable;
  logic              pause;
  logic [DUTY_W-1:0] duty_r;
  logic [DUTY_W-1:0] duty_g;
  logic [DUTY_W-1:0] duty_b;
  logic [2:0]        colour_idx;
  logic              holding;
  logic              wrap;
  logic [1:0]        state_dbg;

  modport master (
    output enable, pause,
    input  duty_r, duty_g, duty_b, colour_idx, holding, wrap, state_dbg
  );

  modport slave (
    input  enable, pause,
    output duty_r, duty_g, duty_b, colour_idx, holding, wrap, state_dbg
  );
endinterface

// File: rtl/rgb_fade_sequencer.sv
// Steps three PWM duty values through a six-colour palette, ramping one LSB per
// step tick between colours and holding each colour for a fixed number of ticks.
module rgb_fade_sequencer #(
  parameter int DUTY_W      = 8,
  parameter int STEP_CYCLES = 46875,
  parameter int HOLD_STEPS  = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rgb_fade_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(STEP_CYCLES - 1);
  localparam logic [HW-1:0]     HOLD_LAST  = HW'(HOLD_STEPS - 1);
  localparam logic [DUTY_W-1:0] FS         = '1;

  state_t            r_state;
  logic [PW-1:0]     r_presc;
  logic [HW-1:0]     r_hold_cnt;
  logic [DUTY_W-1:0] r_duty_r;
  logic [DUTY_W-1:0] r_duty_g;
  logic [DUTY_W-1:0] r_duty_b;
  logic [2:0]        r_colour_idx;
  logic              r_holding;
  logic              r_wrap;

  state_t            w_state;
  logic [PW-1:0]     w_presc;
  logic [HW-1:0]     w_hold_cnt;
  logic [DUTY_W-1:0] w_duty_r;
  logic [DUTY_W-1:0] w_duty_g;
  logic [DUTY_W-1:0] w_duty_b;
  logic [2:0]        w_colour_idx;
  logic              w_holding;
  logic              w_wrap;

  logic              w_tick;
  logic [DUTY_W-1:0] w_tgt_r;
  logic [DUTY_W-1:0] w_tgt_g;
  logic [DUTY_W-1:0] w_tgt_b;
  logic [DUTY_W-1:0] w_step_r;
  logic [DUTY_W-1:0] w_step_g;
  logic [DUTY_W-1:0] w_step_b;
  logic              w_at_target;
  logic [2:0]        w_next_idx;

  function automatic logic [DUTY_W-1:0] step_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt
  );
    if (cur < tgt)      return cur + DUTY_W'(1);
    else if (cur > tgt) return cur - DUTY_W'(1);
    else                return cur;
  endfunction

  // Palette: red, yellow, green, cyan, blue, magenta.
  assign w_tgt_r = (r_colour_idx == 3'd0 || r_colour_idx == 3'd1 || r_colour_idx == 3'd5) ? FS : '0;
  assign w_tgt_g = (r_colour_idx == 3'd1 || r_colour_idx == 3'd2 || r_colour_idx == 3'd3) ? FS : '0;
  assign w_tgt_b = (r_colour_idx == 3'd3 || r_colour_idx == 3'd4 || r_colour_idx == 3'd5) ? FS : '0;

  assign w_step_r    = step_toward(r_duty_r, w_tgt_r);
  assign w_step_g    = step_toward(r_duty_g, w_tgt_g);
  assign w_step_b    = step_toward(r_duty_b, w_tgt_b);
  assign w_at_target = (w_step_r == w_tgt_r) && (w_step_g == w_tgt_g) && (w_step_b == w_tgt_b);
  assign w_next_idx  = (r_colour_idx == 3'd5) ? 3'd0 : r_colour_idx + 3'd1;

  // The prescaler only advances while running and unpaused, so a tick never fires in IDLE or pause.
  assign w_tick = (r_state != S_IDLE) && bus.enable && !bus.pause && (r_presc == PRESC_LAST);

  always_comb begin
    w_state      = r_state;
    w_presc      = r_presc;
    w_hold_cnt   = r_hold_cnt;
    w_duty_r     = r_duty_r;
    w_duty_g     = r_duty_g;
    w_duty_b     = r_duty_b;
    w_colour_idx = r_colour_idx;
    w_holding    = r_holding;
    w_wrap       = 1'b0;

    if (!bus.enable) begin
      w_state      = S_IDLE;
      w_presc      = '0;
      w_hold_cnt   = '0;
      w_duty_r     = '0;
      w_duty_g     = '0;
      w_duty_b     = '0;
      w_colour_idx = 3'd0;
      w_holding    = 1'b0;
    end else if (!bus.pause) begin
      case (r_state)
        S_IDLE: begin
          w_state      = S_RAMP;
          w_presc      = '0;
          w_colour_idx = 3'd0;
        end
        S_RAMP: begin
          w_presc = w_tick ? '0 : r_presc + PW'(1);
          if (w_tick) begin
            w_duty_r = w_step_r;
            w_duty_g = w_step_g;
            w_duty_b = w_step_b;
            if (w_at_target) begin
              w_state    = S_HOLD;
              w_hold_cnt = '0;
              w_holding  = 1'b1;
            end
          end
        end
        S_HOLD: begin
          w_presc = w_tick ? '0 : r_presc + PW'(1);
          if (w_tick) begin
            if (r_hold_cnt == HOLD_LAST) begin
              w_state      = S_RAMP;
              w_hold_cnt   = '0;
              w_colour_idx = w_next_idx;
              w_holding    = 1'b0;
              w_wrap       = (r_colour_idx == 3'd5);
            end else begin
              w_hold_cnt = r_hold_cnt + HW'(1);
            end
          end
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_presc      <= '0;
      r_hold_cnt   <= '0;
      r_duty_r     <= '0;
      r_duty_g     <= '0;
      r_duty_b     <= '0;
      r_colour_idx <= 3'd0;
      r_holding    <= 1'b0;
      r_wrap       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_presc      <= w_presc;
      r_hold_cnt   <= w_hold_cnt;
      r_duty_r     <= w_duty_r;
      r_duty_g     <= w_duty_g;
      r_duty_b     <= w_duty_b;
      r_colour_idx <= w_colour_idx;
      r_holding    <= w_holding;
      r_wrap       <= w_wrap;
    end
  end

  assign bus.duty_r     = r_duty_r;
  assign bus.duty_g     = r_duty_g;
  assign bus.duty_b     = r_duty_b;
  assign bus.colour_idx = r_colour_idx;
  assign bus.holding    = r_holding;
  assign bus.wrap       = r_wrap;
  assign bus.state_dbg  = r_state;

endmodule
